// File: rtl/bit_unpacker.sv
// bit_unpacker: buffers IN_WIDTH-bit words in a small FIFO and hands out
// variable-length fields (0..OUT_WIDTH bits) MSB-first across word boundaries.
// A request waits until enough bits are stored. While a request waits, raising
// flush returns whatever is stored instead.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no request pending, reqready_o=1
// S_WAIT  | request latched, waiting for enough stored bits (or flush)
// S_SERVE | field extracted from the bit buffer, pushout registered
//
// The bit buffer keeps its valid bits right-justified in buf_q[bcnt_q-1:0].
// The oldest bit is at index bcnt_q-1. Consuming a field only lowers bcnt_q.
// A refill shifts a new word in at the bottom.
// IN_WIDTH >= OUT_WIDTH is assumed, so one refill covers any field.
module bit_unpacker #(
    parameter int IN_WIDTH  = 32,
    parameter int DEPTH     = 16,
    parameter int OUT_WIDTH = 15,
    parameter int LEN_WIDTH = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 pushin_i,
    input  logic [IN_WIDTH-1:0]  datain_i,
    output logic                 full_o,
    output logic                 overflow_o,
    input  logic                 reqin_i,
    input  logic [LEN_WIDTH-1:0] reqlen_i,
    input  logic                 flush_i,
    output logic                 reqready_o,
    output logic                 pushout_o,
    output logic [LEN_WIDTH-1:0] lenout_o,
    output logic [OUT_WIDTH-1:0] dataout_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BUF_W  = OUT_WIDTH + IN_WIDTH;
    localparam int BCNT_W = $clog2(BUF_W + 1);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(OUT_WIDTH);
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [BCNT_W-1:0]    OUT_BCNT  = BCNT_W'(OUT_WIDTH);
    localparam logic [BCNT_W-1:0]    IN_BCNT   = BCNT_W'(IN_WIDTH);
    localparam logic [31:0]          IN_W32    = 32'(IN_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    // word FIFO
    logic [IN_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // bit buffer
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

    // request FSM and registered outputs
    state_t              state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                overflow_q, overflow_d;
    logic                pushout_q, pushout_d;
    logic [LEN_WIDTH-1:0] lenout_q, lenout_d;
    logic [OUT_WIDTH-1:0] dataout_q, dataout_d;

    logic                full;
    logic                push_ok;
    logic                refill;
    logic [BCNT_W-1:0]   consume;
    logic [31:0]         stored_bits;
    logic [LEN_WIDTH-1:0] req_len;
    logic [BCNT_W-1:0]   shift_amt;
    logic [BUF_W-1:0]    field_mask;
    logic [BUF_W-1:0]    field;

    assign full        = (count_q == DEPTH_CNT);
    assign push_ok     = pushin_i && !full;
    assign refill      = (bcnt_q < OUT_BCNT) && (count_q != '0);
    assign stored_bits = 32'(count_q) * IN_W32 + 32'(bcnt_q);
    assign req_len     = (reqlen_i > MAX_LEN) ? MAX_LEN : reqlen_i;

    // Field extraction: oldest len_q bits of the buffer, right-justified.
    assign shift_amt  = bcnt_q - BCNT_W'(len_q);
    assign field_mask = (BUF_W'(1) << len_q) - BUF_W'(1);
    assign field      = (buf_q >> shift_amt) & field_mask;

    // FIFO pointers/occupancy and bit buffer next state; push and refill may coincide
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        buf_d    = buf_q;
        bcnt_d   = bcnt_q - consume;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (refill) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            buf_d    = (buf_q << IN_WIDTH) | BUF_W'(mem_q[rd_ptr_q]);
            bcnt_d   = bcnt_q - consume + IN_BCNT;
        end
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(refill);
        overflow_d = pushin_i && full;
    end

    // Request FSM: next state and output values
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        consume   = '0;
        pushout_d = 1'b0;
        lenout_d  = lenout_q;
        dataout_d = dataout_q;
        case (state_q)
            S_IDLE: begin
                if (reqin_i) begin
                    len_d   = req_len;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stored_bits >= 32'(len_q)) begin
                    state_d = S_SERVE;
                end else if (flush_i) begin
                    // stored < len <= OUT_WIDTH here, so it fits in LEN_WIDTH
                    len_d   = LEN_WIDTH'(stored_bits);
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                pushout_d = 1'b1;
                lenout_d  = len_q;
                dataout_d = OUT_WIDTH'(field);
                consume   = BCNT_W'(len_q);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Word storage; contents need no reset because occupancy is tracked by count_q
    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= datain_i;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            buf_q      <= '0;
            bcnt_q     <= '0;
            state_q    <= S_IDLE;
            len_q      <= '0;
            overflow_q <= 1'b0;
            pushout_q  <= 1'b0;
            lenout_q   <= '0;
            dataout_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            bcnt_q     <= bcnt_d;
            state_q    <= state_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            pushout_q  <= pushout_d;
            lenout_q   <= lenout_d;
            dataout_q  <= dataout_d;
        end
    end

    assign full_o     = full;
    assign overflow_o = overflow_q;
    assign reqready_o = (state_q == S_IDLE);
    assign pushout_o  = pushout_q;
    assign lenout_o   = lenout_q;
    assign dataout_o  = dataout_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Self-checking bench for bit_unpacker.
// The reference model is a plain queue of bits in consumption order.
module tb_bit_unpacker;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        pushin_i = 1'b0;
    logic [31:0] datain_i = '0;
    logic        full_o;
    logic        overflow_o;
    logic        reqin_i = 1'b0;
    logic [3:0]  reqlen_i = '0;
    logic        flush_i = 1'b0;
    logic        reqready_o;
    logic        pushout_o;
    logic [3:0]  lenout_o;
    logic [14:0] dataout_o;

    int n_checks = 0;
    int n_errors = 0;
    bit mq[$];

    bit_unpacker dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .pushin_i   (pushin_i),
        .datain_i   (datain_i),
        .full_o     (full_o),
        .overflow_o (overflow_o),
        .reqin_i    (reqin_i),
        .reqlen_i   (reqlen_i),
        .flush_i    (flush_i),
        .reqready_o (reqready_o),
        .pushout_o  (pushout_o),
        .lenout_o   (lenout_o),
        .dataout_o  (dataout_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit drop);
        pushin_i = 1'b1;
        datain_i = w;
        tick();
        pushin_i = 1'b0;
        if (!drop) begin
            for (int i = 31; i >= 0; i--) mq.push_back(w[i]);
        end
    endtask

    task automatic model_take(input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 1) | 32'(mq.pop_front());
    endtask

    task automatic accept_req(input int len, input string tag);
        int guard;
        guard = 0;
        while (!reqready_o && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, "_ready"}, 32'(reqready_o), 1);
        reqin_i  = 1'b1;
        reqlen_i = 4'(len);
        tick();
        reqin_i  = 1'b0;
        chk({tag, "_busy"}, 32'(reqready_o), 0);
    endtask

    task automatic wait_pushout(input int max_cycles, input string tag);
        int c;
        c = 0;
        while (!pushout_o && c < max_cycles) begin
            tick();
            c++;
        end
        chk({tag, "_pushout"}, 32'(pushout_o), 1);
    endtask

    task automatic check_field(input int n, input string tag, input int exp_const);
        logic [31:0] v;
        model_take(n, v);
        chk({tag, "_len"}, 32'(lenout_o), 32'(n));
        chk({tag, "_data"}, 32'(dataout_o), v);
        if (exp_const >= 0) chk({tag, "_const"}, 32'(dataout_o), 32'(exp_const));
    endtask

    // Request with enough bits already stored: pushout exactly 2 cycles after accept.
    task automatic serve_stored(input int len, input string tag, input int exp_const);
        int n;
        n = (len > 15) ? 15 : len;
        accept_req(len, tag);
        tick();
        chk({tag, "_early"}, 32'(pushout_o), 0);
        tick();
        chk({tag, "_pushout"}, 32'(pushout_o), 1);
        chk({tag, "_rdy_after"}, 32'(reqready_o), 1);
        check_field(n, tag, exp_const);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        int len;

        // reset
        reset_i = 1'b1;
        tick();
        tick();
        chk("rst_full", 32'(full_o), 0);
        chk("rst_overflow", 32'(overflow_o), 0);
        chk("rst_reqready", 32'(reqready_o), 1);
        chk("rst_pushout", 32'(pushout_o), 0);
        chk("rst_lenout", 32'(lenout_o), 0);
        chk("rst_dataout", 32'(dataout_o), 0);
        reset_i = 1'b0;
        tick();

        // 1, 2
        push_word(32'hDEADBEEF, 1'b0);
        serve_stored(4, "t1", 'hD);
        serve_stored(15, "t2", 'h756D);
        chk("t2_remaining", 32'(mq.size()), 13);

        // 3: stall until the next word arrives
        accept_req(15, "t3");
        repeat (3) tick();
        chk("t3_stall_rdy", 32'(reqready_o), 0);
        chk("t3_stall_po", 32'(pushout_o), 0);
        push_word(32'h12345678, 1'b0);
        wait_pushout(3, "t3");
        check_field(15, "t3", 'h7BBC);

        // drain the 30 leftover bits so step 4 starts empty
        serve_stored(15, "t3_drain_a", -1);
        serve_stored(15, "t3_drain_b", -1);
        chk("t3_drained", 32'(mq.size()), 0);

        // 4: flush returns the partial field
        push_word(32'hDEADBEEF, 1'b0);
        serve_stored(4, "t4a", 'hD);
        serve_stored(15, "t4b", 'h756D);
        accept_req(15, "t4");
        repeat (2) tick();
        chk("t4_stall_po", 32'(pushout_o), 0);
        flush_i = 1'b1;
        wait_pushout(3, "t4_flush");
        flush_i = 1'b0;
        check_field(13, "t4", 'h1EEF);
        chk("t4_rdy_after", 32'(reqready_o), 1);
        // flush while idle does nothing
        flush_i = 1'b1;
        repeat (3) tick();
        chk("idle_flush_po", 32'(pushout_o), 0);
        chk("idle_flush_len", 32'(lenout_o), 13);
        flush_i = 1'b0;

        // 5: fill to full (first word sits in the bit buffer), overflow, drain
        for (int i = 0; i < 17; i++) push_word($urandom, 1'b0);
        chk("t5_full", 32'(full_o), 1);
        push_word($urandom, 1'b1);
        chk("t5_overflow", 32'(overflow_o), 1);
        tick();
        chk("t5_overflow_pulse", 32'(overflow_o), 0);
        chk("t5_still_full", 32'(full_o), 1);
        for (int i = 0; i < 68; i++) serve_stored(8, "t5_drain", -1);
        chk("t5_not_full", 32'(full_o), 0);
        chk("t5_model_empty", 32'(mq.size()), 0);

        // 6: reset during WAIT
        push_word($urandom, 1'b0);
        accept_req(15, "t6");
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        mq.delete();
        chk("t6_rst_rdy", 32'(reqready_o), 1);
        chk("t6_rst_po", 32'(pushout_o), 0);
        chk("t6_rst_len", 32'(lenout_o), 0);
        chk("t6_rst_data", 32'(dataout_o), 0);
        chk("t6_rst_full", 32'(full_o), 0);
        tick();
        accept_req(4, "t6_nodata");
        repeat (4) tick();
        chk("t6_stall_rdy", 32'(reqready_o), 0);
        chk("t6_stall_po", 32'(pushout_o), 0);
        flush_i = 1'b1;
        wait_pushout(3, "t6_flush0");
        flush_i = 1'b0;
        check_field(0, "t6_flush0", 0);
        serve_stored(0, "t6_len0", 0);

        // randomized traffic against the bit-queue model
        for (int it = 0; it < 80; it++) begin
            if (mq.size() < 200) begin
                repeat ($urandom_range(0, 2)) push_word($urandom, 1'b0);
            end
            len = $urandom_range(0, 15);
            if (mq.size() >= len) begin
                serve_stored(len, "rnd", -1);
            end else begin
                accept_req(len, "rnd_wait");
                tick();
                chk("rnd_stall_po", 32'(pushout_o), 0);
                if ($urandom_range(0, 1) == 1) begin
                    flush_i = 1'b1;
                    wait_pushout(3, "rnd_flush");
                    flush_i = 1'b0;
                    check_field(mq.size(), "rnd_flush", -1);
                end else begin
                    w = $urandom;
                    push_word(w, 1'b0);
                    wait_pushout(3, "rnd_fill");
                    check_field(len, "rnd_fill", -1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
